// File: rtl/fwd_hazard_unit.sv
// Forwarding select and multi-cycle load-use stall unit for the ID/EX stage.
// Optional stall statistics counter enabled by defining FU_STALL_CNT_EN.
module fwd_hazard_unit #(
  parameter int REG_AW   = 5,
  parameter int NUM_SRC  = 2,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC-1:0]        ex_need,
  input  logic [NUM_SRC*REG_AW-1:0] ex_src,
  input  logic                      mem_we,
  input  logic                      mem_is_load,
  input  logic [REG_AW-1:0]         mem_rdst,
  input  logic                      wb_we,
  input  logic [REG_AW-1:0]         wb_rdst,
  input  logic                      flush,
  output logic [2*NUM_SRC-1:0]      fwd_sel,
  output logic                      stall,
  output logic [CNT_W-1:0]          stall_cycles
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [3:0] LAT_M1 = 4'(LOAD_LAT - 1);

  state_t             state, state_nx;
  logic [3:0]         cnt, cnt_nx;
  logic [NUM_SRC-1:0] mem_match, mem_hit, wb_hit;
  logic               hazard;

  // NOTE: every combinational output gets a default before any branch so no latch is inferred.
  always_comb begin
    fwd_sel   = '0;
    mem_match = '0;
    mem_hit   = '0;
    wb_hit    = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      mem_match[i] = mem_we && (mem_rdst == ex_src[i*REG_AW +: REG_AW]);
      mem_hit[i]   = ex_need[i] && mem_match[i];
      wb_hit[i]    = ex_need[i] && wb_we && (wb_rdst == ex_src[i*REG_AW +: REG_AW]);
      // A younger producer in EX/MEM shadows MEM/WB even when it is a load.
      if (mem_hit[i] && !mem_is_load)
        fwd_sel[2*i +: 2] = 2'b10;
      else if (wb_hit[i] && !mem_match[i])
        fwd_sel[2*i +: 2] = 2'b01;
    end
  end

  assign hazard = mem_is_load && (|mem_hit);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    stall    = 1'b0;
    case (state)
      IDLE: begin
        stall = hazard;
        if (hazard && (LOAD_LAT > 1)) begin
          state_nx = WAIT;
          cnt_nx   = LAT_M1;
        end
      end
      WAIT: begin
        stall  = 1'b1;
        cnt_nx = cnt - 4'd1;
        if (cnt == 4'd1)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (flush) begin
      state_nx = IDLE;
      cnt_nx   = '0;
    end
    if (rst)
      stall = 1'b0;
  end

  // NOTE: state flops use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

`ifdef FU_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt <= '0;
    else if (stall && (stall_cnt != {CNT_W{1'b1}}))
      stall_cnt <= stall_cnt + 1'b1;
  end

  assign stall_cycles = stall_cnt;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised forwarding and load-use hazard unit for the 3-stage-plus-memory pipeline. It sits beside the ID/EX register. For each of NUM_SRC source operands it selects the bypass source: EX/MEM ALU result, MEM/WB writeback value, or the register file. It also generates a multi-cycle stall for load-use hazards when data memory latency is LOAD_LAT cycles, tracking the stall with an internal state machine and counter.

## Interface
Parameters:
- REG_AW, 5, register address width
- NUM_SRC, 2, number of source operands checked (1..4)
- LOAD_LAT, 1, data-memory read latency in cycles (1..15); total load-use stall length
- CNT_W, 16, width of the stall statistics counter

Ports:
- clk  in  1  pipeline clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- ex_need  in  NUM_SRC  bit i set: EX instruction reads operand i
- ex_src  in  NUM_SRC*REG_AW  operand i address in bits [i*REG_AW +: REG_AW]
- mem_we  in  1  EX/MEM instruction writes a register
- mem_is_load  in  1  EX/MEM instruction is a memory read (result not yet available)
- mem_rdst  in  REG_AW  EX/MEM destination register
- wb_we  in  1  MEM/WB instruction writes a register
- wb_rdst  in  REG_AW  MEM/WB destination register
- flush  in  1  synchronous pipeline flush; aborts any stall in progress
- fwd_sel  out  2*NUM_SRC  per operand, bits [2i+1:2i]: 2'b10 EX/MEM, 2'b01 MEM/WB, 2'b00 register file
- stall  out  1  freeze PC, IF/ID and ID/EX; bubble into EX/MEM
- stall_cycles  out  CNT_W  saturating count of cycles with stall high

## Operation
- Match: mem_hit[i] = ex_need[i] && mem_we && (mem_rdst == src_i); wb_hit[i] = ex_need[i] && wb_we && (wb_rdst == src_i). Register 0 is not special.
- fwd_sel[i]: 2'b10 if mem_hit[i] && !mem_is_load; else 2'b01 if wb_hit[i] && !(mem_we && mem_rdst == src_i); else 2'b00. Youngest producer always wins. A load match in EX/MEM never falls back to an older WB value.
- hazard = mem_is_load && OR over i of mem_hit[i].
- FSM states: IDLE, WAIT. Counter cnt is 4 bits wide.
  - IDLE: stall = hazard. If hazard && LOAD_LAT > 1 && !flush: go to WAIT with cnt = LOAD_LAT-1. Otherwise stay in IDLE.
  - WAIT: stall = 1 and cnt decrements each cycle. When cnt == 1, go to IDLE. The pipeline holds the load in EX/MEM while in WAIT. hazard is ignored in WAIT.
  - flush in either state: next state IDLE, cnt = 0. stall in the flush cycle is still computed as above.
- Back in IDLE after a stall, the pipeline contract guarantees the load is in MEM/WB. The operand then receives fwd_sel 2'b01 and no further stall.
- stall_cycles increments on every clock edge where stall = 1 and saturates at all-ones.

## Timing
- fwd_sel: combinational, zero latency. It is not forced during a stall.
- stall: combinational from state and inputs. It is forced to 0 while rst is high.
- Load-use stall lasts exactly LOAD_LAT consecutive cycles: the first cycle comes from IDLE, the remaining LOAD_LAT-1 from WAIT.
- Back-to-back hazards: a new hazard in the cycle after returning to IDLE starts a fresh stall with no gap cycle.
- Reset (asynchronous, any time including mid-WAIT): state IDLE, cnt 0, stall_cycles 0.

## Configuration
- FU_STALL_CNT_EN defined: stall_cycles counter is implemented as described.
- FU_STALL_CNT_EN undefined: no counter flops are built; stall_cycles is tied to 0. All other behaviour is identical.

## Test plan
- EX/MEM ALU forward: ex_need=2'b01, src0=5, mem_we=1, mem_is_load=0, mem_rdst=5 -> fwd_sel[1:0]=2'b10, stall=0.
- Priority: src1=7, mem_rdst=7 (ALU), wb_rdst=7, wb_we=1 -> fwd_sel[3:2]=2'b10. Drop mem_we -> 2'b01. Set ex_need[1]=0 -> 2'b00.
- Load-use, LOAD_LAT=3: load to r9 in EX/MEM, src0=9 needed -> stall high for exactly 3 cycles. Next cycle, with the load in WB, fwd_sel[1:0]=2'b01 and stall=0. stall_cycles=3.
- Flush mid-stall, LOAD_LAT=4: assert flush in the 2nd stall cycle -> stall=0 from the 3rd cycle. State returns to IDLE.
- Async reset mid-WAIT -> stall=0 immediately. stall_cycles=0 after reset. No stall resumes after rst deasserts unless hazard is present.
- Saturation with CNT_W=4: hold the hazard condition for 20 cycles -> stall_cycles=15. Without FU_STALL_CNT_EN, stall_cycles stays 0.
